// File: rtl/alu_ex_stage.sv
// Execute-stage ALU with valid/ready handshake and registered result/flags.
// Define ALU_SHIFT_EN to build the iterative 1-bit-per-cycle shifter; otherwise shift codes act as ADD.
module alu_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_funct,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               overflow,
    output logic               busy
);

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_SLL = 3'b010;
    localparam logic [2:0] F_AND = 3'b011;
    localparam logic [2:0] F_OR  = 3'b100;
    localparam logic [2:0] F_SRL = 3'b101;
    localparam logic [2:0] F_NOR = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

`ifdef ALU_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b10
    } state_t;
`endif

    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    function automatic logic sub_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    state_t              ld_state_s;
    logic                accept_s;
    logic [DATA_W-1:0]   sum_s;
    logic [DATA_W-1:0]   diff_s;
    logic                slt_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_ovf_s;
    logic                commit_s;
    logic [DATA_W-1:0]   commit_res_s;
    logic                commit_ovf_s;
    logic [DATA_W-1:0]   result_r;
    logic                zero_r;
    logic                ovf_r;
    logic                out_valid_r;

    assign sum_s    = op_a + op_b;
    assign diff_s   = op_a - op_b;
    assign slt_s    = $signed(op_a) < $signed(op_b);
    assign in_ready = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
    assign accept_s = in_valid && in_ready;

    // Single-cycle ALU for every code that completes at latency 1
    always_comb begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        case (alu_funct)
            F_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf(op_a[DATA_W-1], op_b[DATA_W-1], sum_s[DATA_W-1]);
            end
            F_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_ovf(op_a[DATA_W-1], op_b[DATA_W-1], diff_s[DATA_W-1]);
            end
            F_AND: alu_res_s = op_a & op_b;
            F_OR:  alu_res_s = op_a | op_b;
            F_NOR: alu_res_s = ~(op_a | op_b);
            F_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, slt_s};
`ifndef ALU_SHIFT_EN
            F_SLL, F_SRL: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf(op_a[DATA_W-1], op_b[DATA_W-1], sum_s[DATA_W-1]);
            end
`endif
            default: begin
                alu_res_s = '0;
                alu_ovf_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_SHIFT_EN
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic                is_shift_s;
    logic                shift_done_s;
    logic [DATA_W-1:0]   work_r;
    logic [DATA_W-1:0]   work_step_s;
    logic [SHAMT_W-1:0]  cnt_r;
    logic                dir_r;
    logic                busy_r;

    assign is_shift_s   = (alu_funct == F_SLL) || (alu_funct == F_SRL);
    assign work_step_s  = dir_r ? (work_r >> 1'b1) : (work_r << 1'b1);
    assign shift_done_s = (state_r == SHIFT) && (cnt_r == CNT_ONE);
    assign busy         = busy_r;

    // Destination of an accepted op and the value committed to the result register
    always_comb begin
        ld_state_s   = HOLD;
        commit_s     = 1'b0;
        commit_res_s = alu_res_s;
        commit_ovf_s = alu_ovf_s;
        if (is_shift_s && (shamt != '0)) begin
            ld_state_s = SHIFT;
        end else begin
            ld_state_s = HOLD;
        end
        if (shift_done_s) begin
            commit_s     = 1'b1;
            commit_res_s = work_step_s;
            commit_ovf_s = 1'b0;
        end else if (is_shift_s) begin
            // shamt==0 shifts are a plain pass-through of op_b
            commit_s     = accept_s && (shamt == '0);
            commit_res_s = op_b;
            commit_ovf_s = 1'b0;
        end else begin
            commit_s     = accept_s;
            commit_res_s = alu_res_s;
            commit_ovf_s = alu_ovf_s;
        end
    end

    // Shift working register and down-counter; operands latched on every accept
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r <= '0;
            cnt_r  <= '0;
            dir_r  <= 1'b0;
        end else if (accept_s) begin
            work_r <= op_b;
            cnt_r  <= shamt;
            dir_r  <= (alu_funct == F_SRL);
        end else if (state_r == SHIFT) begin
            work_r <= work_step_s;
            cnt_r  <= cnt_r - CNT_ONE;
        end
    end

    // Busy flag mirrors the next state so it is registered like every other output
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == SHIFT);
        end
    end
`else
    logic unused_shamt_s;

    assign unused_shamt_s = ^shamt;
    assign busy           = 1'b0;

    // Every code completes in one cycle without the shifter
    always_comb begin
        ld_state_s   = HOLD;
        commit_s     = accept_s;
        commit_res_s = alu_res_s;
        commit_ovf_s = alu_ovf_s;
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = ld_state_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_nx_s = ld_state_s;
                end else if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
`ifdef ALU_SHIFT_EN
            SHIFT: begin
                if (shift_done_s) begin
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
`endif
            default: state_nx_s = IDLE;
        endcase
    end

    // Result, flags and out_valid registers; result is held until a new commit
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= '0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nx_s == HOLD);
            if (commit_s) begin
                result_r <= commit_res_s;
                zero_r   <= (commit_res_s == '0);
                ovf_r    <= commit_ovf_s;
            end
        end
    end

    assign result    = result_r;
    assign zero      = zero_r;
    assign overflow  = ovf_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed cases plus random traffic vs. a transaction-level model.
// Honours ALU_SHIFT_EN the same way as the design.
module tb_alu_ex_stage;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_SLL = 3'b010;
    localparam logic [2:0] F_AND = 3'b011;
    localparam logic [2:0] F_OR  = 3'b100;
    localparam logic [2:0] F_SRL = 3'b101;
    localparam logic [2:0] F_NOR = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic        pend_v;
    logic        pend_shift;
    int          pend_ready;
    logic [31:0] pend_res;
    logic        pend_ovf;
    logic        post_reset;
    logic [31:0] specials [5];

    alu_ex_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_funct (alu_funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: the operation's meaning in plain signed/unsigned arithmetic.
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s, output logic [31:0] r, output logic o);
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o  = 1'b0;
        r  = 32'h0;
        case (f)
            F_ADD: begin sr = sa + sb; r = a + b; o = (sr > SMAX) || (sr < SMIN); end
            F_SUB: begin sr = sa - sb; r = a - b; o = (sr > SMAX) || (sr < SMIN); end
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_NOR: r = ~(a | b);
            F_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            F_SLL: r = b << s;
            F_SRL: r = b >> s;
`else
            F_SLL, F_SRL: begin sr = sa + sb; r = a + b; o = (sr > SMAX) || (sr < SMIN); end
`endif
            default: r = 32'h0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s, input logic ordy);
        in_valid  = v;
        alu_funct = f;
        op_a      = a;
        op_b      = b;
        shamt     = s;
        out_ready = ordy;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model.
    task automatic tick();
        logic        exp_ov;
        logic        exp_busy;
        logic        exp_rdy;
        logic        is_sh;
        logic [31:0] r;
        logic        o;
        @(negedge clk);
        cyc++;
        if (post_reset) begin
            check_value("rst_result", result, 32'h0);
            check_value("rst_zero", zero, 32'h0);
            check_value("rst_overflow", overflow, 32'h0);
            post_reset = 1'b0;
        end
        exp_ov   = pend_v && (cyc >= pend_ready);
        exp_busy = pend_v && pend_shift && (cyc < pend_ready);
        exp_rdy  = !pend_v || (exp_ov && out_ready);
        check_value("out_valid", out_valid, exp_ov);
        check_value("busy", busy, exp_busy);
        check_value("in_ready", in_ready, exp_rdy);
        if (exp_ov) begin
            check_value("result", result, pend_res);
            check_value("zero", zero, (pend_res == 32'h0));
            check_value("overflow", overflow, pend_ovf);
        end
        if (reset) begin
            pend_v     = 1'b0;
            post_reset = 1'b1;
        end else begin
            if (exp_ov && out_ready) pend_v = 1'b0;
            if (in_valid && exp_rdy) begin
                model(alu_funct, op_a, op_b, shamt, r, o);
`ifdef ALU_SHIFT_EN
                is_sh = ((alu_funct == F_SLL) || (alu_funct == F_SRL)) && (shamt != 5'd0);
`else
                is_sh = 1'b0;
`endif
                pend_v     = 1'b1;
                pend_res   = r;
                pend_ovf   = o;
                pend_shift = is_sh;
                pend_ready = cyc + (is_sh ? (int'(shamt) + 1) : 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        pend_v     = 1'b0;
        pend_shift = 1'b0;
        pend_ready = 0;
        pend_res   = 32'h0;
        pend_ovf   = 1'b0;
        post_reset = 1'b0;
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;

        reset = 1'b1;
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("reset_out_valid", out_valid, 32'h0);
        check_value("reset_result", result, 32'h0);
        check_value("reset_zero", zero, 32'h0);
        check_value("reset_overflow", overflow, 32'h0);
        check_value("reset_busy", busy, 32'h0);
        check_value("reset_in_ready", in_ready, 32'h1);
        @(posedge clk);
        #1;

        // ADD with signed overflow
        drive(1'b1, F_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        tick();

        // SUB then NOR back-to-back
        drive(1'b1, F_SUB, 32'd5, 32'd5, 5'd0, 1'b1);
        tick();
        drive(1'b1, F_NOR, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        tick();

        // AND held under backpressure while another op waits
        drive(1'b1, F_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 1'b0);
        tick();
        drive(1'b1, F_ADD, 32'd1, 32'd1, 5'd0, 1'b0);
        repeat (3) tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        tick();

        // SLL/SRL codes: iterative shift when built in, ADD otherwise
        drive(1'b1, F_SLL, 32'd2, 32'd3, 5'd7, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (9) tick();
        drive(1'b1, F_SLL, 32'h0, 32'h1, 5'd4, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (6) tick();
        drive(1'b1, F_SRL, 32'h0, 32'h8000_0000, 5'd31, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (33) tick();
        drive(1'b1, F_SLL, 32'h0, 32'h0000_0005, 5'd0, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (2) tick();

        // Reset in the middle of a long shift, then a normal ADD
        drive(1'b1, F_SLL, 32'h0, 32'h1, 5'd20, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, F_ADD, 32'd2, 32'd3, 5'd0, 1'b1);
        tick();
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (2) tick();

        // Random traffic with random stalls on both sides
        repeat (3000) begin
            drive(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), pick(), pick(),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7));
            tick();
        end
        drive(1'b0, F_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
